// File: rtl/debug_pkg.sv
// Shared state encodings and default widths for the MIPS run/halt/step debug sequencer.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } dbg_state_t;

    localparam int DBG_ADDR_W     = 32;
    localparam int DBG_CNT_W      = 32;
    localparam int DBG_STEP_CNT_W = 16;

    function automatic logic is_stopped(input dbg_state_t s);
        return (s == ST_HALT) || (s == ST_BREAK);
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: o_rise is high in the first cycle i_sig is seen high.
// Zero-latency output; the previous level is held in one register.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d <= 1'b0;
        end else begin
            r_d <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_d;

endmodule

// File: rtl/mips_debug_ctrl.sv
// Run/halt/single-step/breakpoint sequencer producing the MIPS pipeline enable cpu_en.
// Optional MIPS_DEBUG_BP_COUNT_EN: break only on the bp_count-th breakpoint match.
module mips_debug_ctrl
    import debug_pkg::*;
#(
    parameter int ADDR_W     = DBG_ADDR_W,
    parameter int CNT_W      = DBG_CNT_W,
    parameter int STEP_CNT_W = DBG_STEP_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  debug_en,
    input  logic                  debug_step,
    input  logic                  bp_en,
    input  logic [ADDR_W-1:0]     bp_addr,
    input  logic [ADDR_W-1:0]     pc,
`ifdef MIPS_DEBUG_BP_COUNT_EN
    input  logic [7:0]            bp_count,
`endif
    output logic                  cpu_en,
    output logic                  halted,
    output logic                  bp_hit,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [STEP_CNT_W-1:0] step_cnt
);

    localparam logic [CNT_W-1:0]      CYC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_CNT_W-1:0] STEP_ONE = {{(STEP_CNT_W-1){1'b0}}, 1'b1};

    dbg_state_t              r_state;
    dbg_state_t              r_ret;
    logic                    r_halted;
    logic                    r_bp_hit;
    logic                    r_bp_mask;
    logic [CNT_W-1:0]        r_cycle_cnt;
    logic [STEP_CNT_W-1:0]   r_step_cnt;

    dbg_state_t              w_state_nxt;
    dbg_state_t              w_ret_nxt;
    logic                    w_step_edge;
    logic                    w_bp_match;
    logic                    w_brk;
    logic                    w_cpu_en;

    edge_rise u_step_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (debug_step),
        .o_rise (w_step_edge)
    );

    // The mask lets a resumed run execute the instruction sitting on the breakpoint.
    assign w_bp_match = bp_en & (pc == bp_addr) & ~r_bp_mask;

`ifdef MIPS_DEBUG_BP_COUNT_EN
    logic [7:0] r_match_cnt;
    logic [7:0] w_eff_cnt;

    assign w_eff_cnt = (bp_count == 8'd0) ? 8'd1 : bp_count;
    assign w_brk     = w_bp_match & (({1'b0, r_match_cnt} + 9'd1) >= {1'b0, w_eff_cnt});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt <= 8'd0;
        end else if (w_state_nxt == ST_BREAK && r_state != ST_BREAK) begin
            r_match_cnt <= 8'd0;
        end else if (r_state == ST_RUN && w_bp_match && !w_brk) begin
            r_match_cnt <= r_match_cnt + 8'd1;
        end
    end
`else
    assign w_brk = w_bp_match;
`endif

    assign w_cpu_en = ((r_state == ST_RUN) & ~w_brk) | (r_state == ST_STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        case (r_state)
            ST_RUN: begin
                if (debug_en) begin
                    w_state_nxt = ST_HALT;
                end else if (w_brk) begin
                    w_state_nxt = ST_BREAK;
                end
            end
            ST_HALT: begin
                if (w_step_edge) begin
                    w_state_nxt = ST_STEP;
                    w_ret_nxt   = ST_HALT;
                end else if (!debug_en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_BREAK: begin
                if (w_step_edge) begin
                    w_state_nxt = ST_STEP;
                    w_ret_nxt   = ST_BREAK;
                end else if (debug_en) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_STEP: begin
                w_state_nxt = r_ret;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_ret       <= ST_HALT;
            r_halted    <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_bp_mask   <= 1'b1;
            r_cycle_cnt <= '0;
            r_step_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ret    <= w_ret_nxt;
            r_halted <= is_stopped(w_state_nxt);

            if (w_cpu_en) begin
                r_cycle_cnt <= r_cycle_cnt + CYC_ONE;
            end
            if (w_state_nxt == ST_STEP && r_state != ST_STEP) begin
                r_step_cnt <= r_step_cnt + STEP_ONE;
            end

            if (w_state_nxt == ST_RUN && r_state != ST_RUN) begin
                r_bp_hit <= 1'b0;
            end else if (r_state == ST_RUN && w_state_nxt == ST_BREAK) begin
                r_bp_hit <= 1'b1;
            end

            if (r_state == ST_HALT && w_state_nxt == ST_RUN) begin
                r_bp_mask <= 1'b1;
            end else if (r_state == ST_RUN && w_cpu_en) begin
                r_bp_mask <= 1'b0;
            end
        end
    end

    assign cpu_en    = w_cpu_en;
    assign halted    = r_halted;
    assign bp_hit    = r_bp_hit;
    assign state     = r_state;
    assign cycle_cnt = r_cycle_cnt;
    assign step_cnt  = r_step_cnt;

endmodule
